// File: rtl/npc_pkg.sv
// Shared definitions for the npc load/store path: width codes, exception
// causes, LSU state encoding and access legality helpers.
package npc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] EXC_NONE        = 2'b00;
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL     = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EXC  = 2'd3;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Unsigned-extension codes have no store form; D and WU need a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we, input int xlen);
    if (f3 == 3'b111) return 1'b0;
    if (xlen == 32 && (f3 == F3_D || f3 == F3_WU)) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return |lo[1:0];
      2'b11:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering for the LSU: store data/mask placement and load
// lane extraction with sign or zero extension.
module npc_lsu_align
  import npc_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OFS = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OFS-1:0]  ofs,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] st_data,
  output logic [NB-1:0]   st_mask,
  output logic [XLEN-1:0] ld_data
);

  int              nbytes;
  int              sh;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] rtop;

  always_comb begin
    nbytes = size_bytes(funct3[1:0]);
    if (nbytes > NB) nbytes = NB;
    sh      = XLEN - 8 * nbytes;
    st_data = wdata << {ofs, 3'b000};
    st_mask = ({NB{1'b1}} >> (NB - nbytes)) << ofs;
    // Push the selected field to the top, then shift back down to extend.
    rsh  = rdata >> {ofs, 3'b000};
    rtop = rsh << sh;
    if (funct3[2]) ld_data = rtop >> sh;
    else           ld_data = $signed(rtop) >>> sh;
  end

endmodule

// File: rtl/npc_lsu.sv
// Handshaked load/store unit: one request at a time from EX, valid/grant
// memory port, aligned store data, extended load writeback, access faults.
module npc_lsu
  import npc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFS   = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              hold_flag_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [NB-1:0]     mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              st_done_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o,
  output logic [ADDR_W-1:0] exc_addr_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("npc_lsu: XLEN must be 32 or 64");
  end

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [1:0]        cause_q;
  logic              wb_valid_q;
  logic              st_done_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;

  logic              in_req;
  logic              legal;
  logic              misal;
  logic [XLEN-1:0]   st_data;
  logic [NB-1:0]     st_mask;
  logic [XLEN-1:0]   ld_data;

  assign legal = f3_legal(req_funct3_i, req_we_i, XLEN);
  assign misal = misaligned(req_funct3_i[1:0], req_addr_i[2:0]);

  npc_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (f3_q),
    .ofs     (addr_q[OFS-1:0]),
    .wdata   (wdata_q),
    .rdata   (mem_rdata_i),
    .st_data (st_data),
    .st_mask (st_mask),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cause_q    <= EXC_NONE;
      wb_valid_q <= 1'b0;
      st_done_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      st_done_q  <= 1'b0;
      case (state)
        S_IDLE: if (req_valid_i) begin
          we_q    <= req_we_i;
          f3_q    <= req_funct3_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          rd_q    <= req_rd_i;
          if (!legal) begin
            state   <= S_EXC;
            cause_q <= EXC_ILLEGAL;
          end else if (misal) begin
            state   <= S_EXC;
            cause_q <= req_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          end else begin
            state   <= S_REQ;
          end
        end
        S_REQ: if (mem_gnt_i) begin
          if (we_q) begin
            st_done_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state     <= S_WAIT;
          end
        end
        S_WAIT: if (mem_rvalid_i) begin
          wb_valid_q <= 1'b1;
          wb_data_q  <= ld_data;
          wb_rd_q    <= rd_q;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs are forced to zero outside REQ so idle cycles look clean.
  assign in_req      = (state == S_REQ);
  assign req_ready_o = (state == S_IDLE);
  assign hold_flag_o = (state != S_IDLE);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && we_q;
  assign mem_addr_o  = in_req ? {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
  assign mem_wdata_o = in_req ? st_data : '0;
  assign mem_wmask_o = (in_req && we_q) ? st_mask : '0;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign st_done_o   = st_done_q;
  assign exc_o       = (state == S_EXC);
  assign exc_cause_o = (state == S_EXC) ? cause_q : EXC_NONE;
  assign exc_addr_o  = (state == S_EXC) ? addr_q : '0;

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: a 32-bit and a 64-bit instance, a transaction-level
// model checked every cycle, and hand-computed literal spot checks.
module tb_npc_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata = '0;
  logic [4:0]  rd = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;

  always #5 clk = ~clk;

  logic        r32, h32, mq32, mw32, wbv32, sd32, ex32;
  logic [31:0] ma32, mwd32, wbd32, ea32;
  logic [3:0]  mk32;
  logic [4:0]  wbr32;
  logic [1:0]  ec32;
  logic        r64, h64, mq64, mw64, wbv64, sd64, ex64;
  logic [31:0] ma64, ea64;
  logic [63:0] mwd64, wbd64;
  logic [7:0]  mk64;
  logic [4:0]  wbr64;
  logic [1:0]  ec64;

  npc_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .req_valid_i(valid[0]), .req_ready_o(r32), .req_we_i(we),
    .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata[31:0]), .req_rd_i(rd),
    .hold_flag_o(h32), .mem_req_o(mq32), .mem_we_o(mw32), .mem_addr_o(ma32),
    .mem_wdata_o(mwd32), .mem_wmask_o(mk32), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata[31:0]), .wb_valid_o(wbv32), .wb_rd_o(wbr32), .wb_data_o(wbd32),
    .st_done_o(sd32), .exc_o(ex32), .exc_cause_o(ec32), .exc_addr_o(ea32)
  );

  npc_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .req_valid_i(valid[1]), .req_ready_o(r64), .req_we_i(we),
    .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata), .req_rd_i(rd),
    .hold_flag_o(h64), .mem_req_o(mq64), .mem_we_o(mw64), .mem_addr_o(ma64),
    .mem_wdata_o(mwd64), .mem_wmask_o(mk64), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .wb_valid_o(wbv64), .wb_rd_o(wbr64), .wb_data_o(wbd64),
    .st_done_o(sd64), .exc_o(ex64), .exc_cause_o(ec64), .exc_addr_o(ea64)
  );

  typedef struct packed {
    logic ready, hold, mreq, mwe;
    logic [31:0] maddr;
    logic [63:0] mwdata;
    logic [7:0]  mask;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    logic        std, exc;
    logic [1:0]  cause;
    logic [31:0] eaddr;
  } obs_t;

  // Model: where the single outstanding transaction stands (phase 1 = waiting
  // for grant, 2 = waiting for data) plus the pulses due this cycle.
  typedef struct packed {
    bit          busy, exc_p, st_p, wb_p;
    int          phase;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd, wb;
    logic [4:0]  rd;
    logic [1:0]  cause;
  } mdl_t;

  obs_t act [2];
  mdl_t mdl [2];
  bit   armed = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  initial begin
    mdl[0] = '0;
    mdl[1] = '0;
  end

  always_comb begin
    act[0] = '0;
    act[0].ready = r32; act[0].hold = h32; act[0].mreq = mq32; act[0].mwe = mw32;
    act[0].maddr = ma32; act[0].mwdata = {32'h0, mwd32}; act[0].mask = {4'h0, mk32};
    act[0].wbv = wbv32; act[0].wbrd = wbr32; act[0].wbd = {32'h0, wbd32};
    act[0].std = sd32; act[0].exc = ex32; act[0].cause = ec32; act[0].eaddr = ea32;
    act[1] = '0;
    act[1].ready = r64; act[1].hold = h64; act[1].mreq = mq64; act[1].mwe = mw64;
    act[1].maddr = ma64; act[1].mwdata = mwd64; act[1].mask = mk64;
    act[1].wbv = wbv64; act[1].wbrd = wbr64; act[1].wbd = wbd64;
    act[1].std = sd64; act[1].exc = ex64; act[1].cause = ec64; act[1].eaddr = ea64;
  end

  function automatic logic [63:0] xmask(int k);
    return (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] load_val(mdl_t m, int k);
    int          nb    = (k == 1) ? 8 : 4;
    int          off   = int'(m.addr % nb);
    int          bytes = 1 << m.f3[1:0];
    logic [63:0] v     = (rdata & xmask(k)) >> (8 * off);
    logic [63:0] lim;
    if (bytes < 8) begin
      lim = 64'd1 << (8 * bytes);
      v   = v % lim;
      if (!m.f3[2] && v >= (lim >> 1)) v = v | ~(lim - 64'd1);
    end
    return v & xmask(k);
  endfunction

  function automatic mdl_t step(mdl_t m, int k);
    mdl_t n  = m;
    int   xl = (k == 1) ? 64 : 32;
    int   bytes;
    n.st_p = 1'b0;
    n.wb_p = 1'b0;
    if (rst) return '0;
    if (m.exc_p) begin
      n.exc_p = 1'b0;
      n.busy  = 1'b0;
    end else if (!m.busy) begin
      if (valid[k]) begin
        n.we = we; n.f3 = f3; n.addr = addr; n.wd = wdata & xmask(k); n.rd = rd;
        n.busy = 1'b1;
        bytes  = 1 << f3[1:0];
        if (f3 == 3'd7 || (xl == 32 && (f3 == 3'd3 || f3 == 3'd6)) || (we && f3[2])) begin
          n.exc_p = 1'b1; n.cause = 2'd3;
        end else if (addr % bytes != 0) begin
          n.exc_p = 1'b1; n.cause = we ? 2'd2 : 2'd1;
        end else begin
          n.phase = 1;
        end
      end
    end else if (m.phase == 1) begin
      if (gnt) begin
        if (m.we) begin n.st_p = 1'b1; n.busy = 1'b0; n.phase = 0; end
        else n.phase = 2;
      end
    end else if (m.phase == 2 && rvalid) begin
      n.wb_p = 1'b1; n.busy = 1'b0; n.phase = 0; n.wb = load_val(m, k);
    end
    return n;
  endfunction

  function automatic obs_t exp_of(mdl_t m, int k);
    obs_t e     = '0;
    int   nb    = (k == 1) ? 8 : 4;
    int   off   = int'(m.addr % nb);
    int   bytes = 1 << m.f3[1:0];
    e.ready = !m.busy;
    e.hold  = m.busy;
    if (m.phase == 1) begin
      e.mreq   = 1'b1;
      e.mwe    = m.we;
      e.maddr  = m.addr - 32'(off);
      e.mwdata = (m.wd << (8 * off)) & xmask(k);
      if (m.we) e.mask = 8'(((1 << bytes) - 1) << off);
    end
    if (m.exc_p) begin e.exc = 1'b1; e.cause = m.cause; e.eaddr = m.addr; end
    e.std = m.st_p;
    e.wbv = m.wb_p;
    if (m.wb_p) begin e.wbrd = m.rd; e.wbd = m.wb; end
    return e;
  endfunction

  always @(posedge clk) begin
    mdl[0] <= step(mdl[0], 0);
    mdl[1] <= step(mdl[1], 1);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        e = exp_of(mdl[k], k);
        a = act[k];
        if (!e.wbv) begin a.wbd = '0; a.wbrd = '0; end
        vecs++;
        if (a !== e) begin
          errs++;
          $display("FAIL cycle lsu%0d t=%0t: got %h want %h", k, $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic txn(input int k, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [63:0] wd, input logic [4:0] r, input int gd,
                     input logic [63:0] rdat, input int rvd, input int gap);
    valid[k] = 1'b1; we = w; f3 = f; addr = a; wdata = wd; rd = r;
    tick();
    valid[k] = 1'b0;
    repeat (gd) tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    if (!w) begin
      repeat (rvd) tick();
      rvalid = 1'b1; rdata = rdat;
      tick();
      rvalid = 1'b0;
    end
    repeat (gap) tick();
  endtask

  localparam logic [63:0] RD = 64'hF1E2_D3C4_B5A6_9788;

  initial begin
    @(posedge clk);
    armed = 1'b1;
    tick();
    chk("rst_ready32", r32, 1); chk("rst_hold32", h32, 0); chk("rst_mreq32", mq32, 0);
    chk("rst_maddr32", ma32, 0); chk("rst_wbv32", wbv32, 0); chk("rst_exc32", ex32, 0);
    chk("rst_ready64", r64, 1); chk("rst_wbd64", wbd64, 0);
    rst = 1'b0;

    // LB, lane 3 of 0x80FFFF00
    tick();
    valid[0] = 1; we = 0; f3 = 3'b000; addr = 32'h8000_0003; rd = 5'd7; wdata = '0;
    tick(); valid[0] = 0;
    chk("lb_mreq", mq32, 1); chk("lb_maddr", ma32, 64'h8000_0000); gnt = 1;
    tick(); gnt = 0; rvalid = 1; rdata = 64'h80FF_FF00;
    chk("lb_hold", h32, 1);
    tick(); rvalid = 0;
    chk("lb_wbv", wbv32, 1); chk("lb_wbd", wbd32, 64'hFFFF_FF80); chk("lb_rd", wbr32, 7);
    chk("lb_hold_pulse", h32, 0); chk("lb_ready", r32, 1);

    // SH to upper half
    tick();
    valid[0] = 1; we = 1; f3 = 3'b001; addr = 32'h8000_0002; wdata = 64'h0000_ABCD;
    tick(); valid[0] = 0;
    chk("sh_wdata", mwd32, 64'hABCD_0000); chk("sh_mask", mk32, 4'b1100); gnt = 1;
    tick(); gnt = 0;
    chk("sh_done", sd32, 1); chk("sh_ready", r32, 1);

    // misaligned LW; grant during EXC must be ignored
    tick();
    valid[0] = 1; we = 0; f3 = 3'b010; addr = 32'h8000_0002;
    tick(); valid[0] = 0;
    chk("lwmis_exc", ex32, 1); chk("lwmis_cause", ec32, 2'b01);
    chk("lwmis_addr", ea32, 64'h8000_0002); chk("lwmis_mreq", mq32, 0); gnt = 1;
    tick(); gnt = 0;
    chk("lwmis_ready", r32, 1); chk("lwmis_mreq2", mq32, 0);

    // SW with grant held off three cycles
    tick();
    valid[0] = 1; we = 1; f3 = 3'b010; addr = 32'h0000_1000; wdata = 64'h1234_5678;
    tick(); valid[0] = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("swdly_mreq", mq32, 1); chk("swdly_addr", ma32, 64'h1000);
      chk("swdly_mask", mk32, 4'b1111); chk("swdly_hold", h32, 1);
      if (i == 4) gnt = 1;
      tick();
    end
    gnt = 0;
    chk("swdly_done", sd32, 1);

    // reset while waiting for load data; the late rvalid is dropped
    tick();
    valid[0] = 1; we = 0; f3 = 3'b010; addr = 32'h0000_0020; rd = 5'd9;
    tick(); valid[0] = 0; gnt = 1;
    tick(); gnt = 0; chk("rstw_hold", h32, 1); rst = 1;
    tick(); rst = 0; rvalid = 1; rdata = 64'h5555_AAAA;
    chk("rstw_ready", r32, 1); chk("rstw_hold0", h32, 0);
    tick(); rvalid = 0;
    chk("rstw_nowb", wbv32, 0); chk("rstw_ready2", r32, 1);

    // XLEN=64 LWU from upper word
    tick();
    valid[1] = 1; we = 0; f3 = 3'b110; addr = 32'h0010_0004; rd = 5'd3;
    tick(); valid[1] = 0; chk("lwu_maddr", ma64, 64'h0010_0000); gnt = 1;
    tick(); gnt = 0; rvalid = 1; rdata = 64'h8765_4321_0000_0000;
    tick(); rvalid = 0;
    chk("lwu_wbv", wbv64, 1); chk("lwu_wbd", wbd64, 64'h0000_0000_8765_4321);

    // LD on 32-bit instance is illegal
    tick();
    valid[0] = 1; we = 0; f3 = 3'b011; addr = 32'h0000_0040;
    tick(); valid[0] = 0;
    chk("ld32_exc", ex32, 1); chk("ld32_cause", ec32, 2'b11);
    tick(); tick();

    // Model-checked directed vectors, several issued back-to-back
    for (int o = 0; o < 4; o++) txn(0, 1, 3'b000, 32'h200 + o, 64'hA5, 0, o, 0, 0, 0);
    txn(0, 0, 3'b000, 32'h301, 0, 1, 0, RD, 0, 0);
    txn(0, 0, 3'b100, 32'h302, 0, 2, 1, RD, 2, 0);
    txn(0, 0, 3'b001, 32'h302, 0, 3, 0, RD, 0, 1);
    txn(0, 0, 3'b101, 32'h300, 0, 4, 0, RD, 1, 0);
    txn(0, 0, 3'b010, 32'h304, 0, 5, 2, RD, 0, 0);
    txn(0, 1, 3'b001, 32'h301, 64'hBEEF, 0, 0, 0, 0, 1);
    txn(0, 1, 3'b100, 32'h300, 64'h11, 0, 0, 0, 0, 1);
    txn(0, 0, 3'b111, 32'h300, 0, 6, 0, RD, 0, 1);
    txn(0, 0, 3'b110, 32'h300, 0, 6, 0, RD, 0, 1);
    txn(1, 1, 3'b011, 32'h408, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0);
    txn(1, 1, 3'b010, 32'h404, 64'hCAFE_F00D, 0, 2, 0, 0, 0);
    txn(1, 1, 3'b000, 32'h407, 64'h99, 0, 0, 0, 0, 0);
    txn(1, 0, 3'b011, 32'h410, 0, 10, 1, RD, 1, 0);
    txn(1, 0, 3'b010, 32'h404, 0, 11, 0, RD, 0, 0);
    txn(1, 0, 3'b101, 32'h406, 0, 12, 0, RD, 3, 0);
    txn(1, 0, 3'b000, 32'h405, 0, 13, 0, RD, 0, 1);
    txn(1, 0, 3'b011, 32'h404, 0, 14, 0, RD, 0, 1);
    txn(1, 1, 3'b011, 32'h40C, 64'h1, 0, 0, 0, 0, 1);
    txn(1, 1, 3'b110, 32'h400, 64'h1, 0, 0, 0, 0, 1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
